// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the raw OV7670 parallel bus in the clk domain and assembles RGB565 pixels
module ov7670_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_done,
    output logic              frame_err
);
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W:0] PIX_ONE = (ADDR_W + 1)'(1);
    localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE + 1);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [31:0] TMO = 32'(2 * H_ACTIVE * V_ACTIVE + 65536 - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, ERR_HOLD} state_t;

    state_t            state;
    logic [10:0]       s1, s2;
    logic              pclk_q, vsync_q, href_q;
    logic              pclk_rise, vs_fall, vs_rise, href_fall;
    logic [7:0]        d_e;
    logic [7:0]        hi;
    logic              phase, err;
    logic [ADDR_W:0]   pix_cnt;
    logic [COL_W-1:0]  col;
    logic [31:0]       idle_cnt;

    // two-flop synchronizer for the whole bus, then registered edge flags aligned with data and href
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            pclk_q <= 1'b0;
            vsync_q <= 1'b0;
            href_q <= 1'b0;
            pclk_rise <= 1'b0;
            vs_fall <= 1'b0;
            vs_rise <= 1'b0;
            href_fall <= 1'b0;
            d_e <= '0;
        end else begin
            s1 <= {cam_pclk, cam_vsync, cam_href, cam_d};
            s2 <= s1;
            pclk_q <= s2[10];
            vsync_q <= s2[9];
            href_q <= s2[8];
            pclk_rise <= s2[10] & ~pclk_q;
            vs_fall <= ~s2[9] & vsync_q;
            vs_rise <= s2[9] & ~vsync_q;
            href_fall <= ~s2[8] & href_q;
            d_e <= s2[7:0];
        end
    end

    // capture FSM: byte pairing, pixel/column counting, error tracking and frame reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pix_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            pix_data <= '0;
            pix_addr <= '0;
            hi <= '0;
            phase <= 1'b0;
            err <= 1'b0;
            pix_cnt <= '0;
            col <= '0;
            idle_cnt <= '0;
        end else begin
            pix_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            if (!cfg_done) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        if (vs_fall) begin
                            state <= CAPTURE;
                            pix_cnt <= '0;
                            col <= '0;
                            phase <= 1'b0;
                            err <= 1'b0;
                            idle_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            frame_done <= 1'b1;
                            frame_err <= err | (pix_cnt != TOTAL);
                            state <= WAIT_FRAME;
                        end else begin
                            idle_cnt <= pclk_rise ? '0 : idle_cnt + 32'd1;
                            if (!pclk_rise && idle_cnt == TMO && !vsync_q)
                                state <= ERR_HOLD;
                            if (!href_q) begin
                                phase <= 1'b0;
                                if (phase)
                                    err <= 1'b1;
                            end else if (pclk_rise) begin
                                phase <= ~phase;
                                if (!phase) begin
                                    hi <= d_e;
                                end else if (pix_cnt == TOTAL) begin
                                    err <= 1'b1;
                                end else begin
                                    pix_valid <= 1'b1;
                                    pix_data <= {hi, d_e};
                                    pix_addr <= pix_cnt[ADDR_W-1:0];
                                    pix_cnt <= pix_cnt + PIX_ONE;
                                    col <= (col == COL_MAX) ? col : col + COL_ONE;
                                end
                            end
                            if (href_fall) begin
                                col <= '0;
                                if (col != COL_END)
                                    err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        frame_done <= 1'b1;
                        frame_err <= 1'b1;
                        state <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed camera-bus stimulus with a queue scoreboard checked by a monitor
module tb_ov7670_capture;
    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_done = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b1;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_d = 8'h00;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic          frame_done;
    logic          frame_err;

    pix_t pq[$];
    logic fq[$];
    pix_t pe, pp;
    logic fe;
    int passed = 0;
    int total = 0;
    int cyc = 0;
    int pv_cyc = 0;
    int rise_cyc = 0;
    int exp_addr = 0;
    logic [7:0] bval = 8'h00;
    logic [7:0] hi_b = 8'h00;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_done(cfg_done),
        .cam_pclk(cam_pclk),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_d(cam_d),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_addr(pix_addr),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every output event is compared against the head of its expectation queue
    always @(negedge clk) begin
        if (pix_valid) begin
            pv_cyc = cyc;
            total++;
            if (pq.size() == 0) begin
                $display("FAIL unexpected_pixel: got addr=%0d data=%h, required no pix_valid", pix_addr, pix_data);
            end else begin
                pe = pq.pop_front();
                if (pix_addr === pe.addr && pix_data === pe.data)
                    passed++;
                else
                    $display("FAIL pixel: got addr=%0d data=%h, required addr=%0d data=%h", pix_addr, pix_data, pe.addr, pe.data);
            end
        end
        if (frame_done) begin
            total++;
            if (fq.size() == 0) begin
                $display("FAIL unexpected_frame_done: got err=%0b, required no frame_done", frame_err);
            end else begin
                fe = fq.pop_front();
                if (frame_err === fe)
                    passed++;
                else
                    $display("FAIL frame_err: got %0b, required %0b", frame_err, fe);
            end
        end
        if (frame_err && !frame_done) begin
            total++;
            $display("FAIL frame_err_stray: got 1 without frame_done, required 0");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pclk_byte(input logic [7:0] b);
        cam_d = b;
        wait_clk(2);
        cam_pclk = 1'b1;
        rise_cyc = cyc;
        wait_clk(2);
        cam_pclk = 1'b0;
    endtask

    task automatic send_line(input int nbytes, input int npush, input bit keep);
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            if (i % 2 == 0) begin
                hi_b = bval;
            end else if (i / 2 < npush) begin
                pp.addr = exp_addr[AW-1:0];
                pp.data = {hi_b, bval};
                pq.push_back(pp);
                exp_addr++;
            end
            pclk_byte(bval);
            bval++;
        end
        if (!keep) begin
            cam_href = 1'b0;
            wait_clk(6);
        end
    endtask

    task automatic frame_begin();
        cam_vsync = 1'b0;
        exp_addr = 0;
        wait_clk(6);
    endtask

    task automatic frame_end(input bit push, input logic err);
        if (push)
            fq.push_back(err);
        cam_vsync = 1'b1;
        wait_clk(10);
        check("pixel_queue_drained", pq.size(), 0);
        check("frame_queue_drained", fq.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_pix_addr"}, pix_addr, 0);
    endtask

    task automatic good_frame();
        frame_begin();
        send_line(8, 4, 0);
        send_line(8, 4, 0);
        frame_end(1, 1'b0);
    endtask

    initial begin
        wait_clk(3);
        check_zero_outputs("reset");
        rst = 1'b0;
        cfg_done = 1'b1;
        wait_clk(4);

        bval = 8'h00;
        good_frame();

        frame_begin();
        cam_href = 1'b1;
        pp.addr = '0;
        pp.data = 16'hABCD;
        pq.push_back(pp);
        pclk_byte(8'hAB);
        pclk_byte(8'hCD);
        cam_href = 1'b0;
        wait_clk(6);
        check("latency", pv_cyc - rise_cyc, 4);
        frame_end(1, 1'b1);

        frame_begin();
        send_line(6, 3, 0);
        send_line(8, 4, 0);
        frame_end(1, 1'b1);
        good_frame();

        frame_begin();
        send_line(9, 4, 0);
        send_line(8, 4, 0);
        frame_end(1, 1'b1);

        frame_begin();
        send_line(8, 4, 0);
        send_line(8, 4, 0);
        send_line(8, 0, 0);
        frame_end(1, 1'b1);

        frame_begin();
        send_line(4, 2, 1);
        wait_clk(4);
        cfg_done = 1'b0;
        send_line(4, 0, 0);
        send_line(8, 0, 0);
        frame_end(0, 1'b0);
        cfg_done = 1'b1;
        wait_clk(4);
        good_frame();

        frame_begin();
        send_line(4, 2, 1);
        wait_clk(4);
        rst = 1'b1;
        wait_clk(1);
        check_zero_outputs("mid_reset");
        rst = 1'b0;
        send_line(4, 0, 0);
        send_line(8, 0, 0);
        frame_end(0, 1'b0);
        good_frame();

        fq.push_back(1'b1);
        frame_begin();
        wait_clk(65600);
        frame_end(0, 1'b0);
        good_frame();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The block SHALL have the following parameters:
- H_ACTIVE, default 320, pixels per line.
- V_ACTIVE, default 240, lines per frame.
- ADDR_W, default 17, width of pix_addr; 2^ADDR_W SHALL be at least H_ACTIVE*V_ACTIVE.
REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset; synchronous and active-high.
- cfg_done  in  1  level signal from the SCCB configuration block; high means the sensor is configured.
- cam_pclk  in  1  raw sensor pixel clock; treated as data, never used as a clock.
- cam_vsync  in  1  raw sensor frame sync; high during vertical blanking.
- cam_href  in  1  raw sensor line-valid.
- cam_d  in  8  raw sensor data byte.
- pix_data  out  16  captured RGB565 pixel, first byte in bits [15:8].
- pix_valid  out  1  one-cycle strobe qualifying pix_data and pix_addr.
- pix_addr  out  ADDR_W  linear pixel index within the frame.
- frame_done  out  1  one-cycle strobe at end of frame.
- frame_err  out  1  frame error flag, valid while frame_done is high.

Function
REQ-003 cam_pclk, cam_vsync, cam_href and cam_d SHALL each pass through an identical two-flop synchronizer, so all four stay time-aligned.
REQ-004 A pclk rising edge SHALL be detected as (synchronized pclk high) AND (its one-cycle-delayed copy low).
REQ-005 vsync falling and rising edges SHALL be detected in the same way.
REQ-006 The block is only required to work when the clk frequency is at least 4x the pclk frequency.
REQ-007 The FSM SHALL have four states: IDLE, WAIT_FRAME, CAPTURE, ERR_HOLD.
REQ-008 IDLE SHALL move to WAIT_FRAME when cfg_done is 1.
REQ-009 WAIT_FRAME SHALL move to CAPTURE on a vsync falling edge. On that transition the pixel counter, column counter, byte phase and error flag SHALL all be cleared.
REQ-010 CAPTURE SHALL handle pclk rising edges while synchronized href is 1 as follows:
- Byte phase 0: latch the byte as the high byte, then set phase to 1.
- Byte phase 1: form a pixel from {high byte, this byte}, then set phase to 0.
REQ-011 When a pixel is formed from a pclk edge detected in cycle N, pix_valid SHALL be 1 in cycle N+1 only.
REQ-012 In the pix_valid cycle, pix_addr SHALL equal the current pixel counter value. The pixel counter and column counter SHALL then increment.
REQ-013 Byte phase SHALL reset to 0 whenever synchronized href is 0. An odd trailing byte SHALL be discarded and SHALL set the error flag.
REQ-014 On an href falling edge in CAPTURE:
- If the column count is not equal to H_ACTIVE, the error flag SHALL be set.
- The column counter SHALL be cleared.
REQ-015 When the pixel counter has reached H_ACTIVE*V_ACTIVE, further pixels SHALL be dropped (no pix_valid) and SHALL set the error flag. The counter SHALL saturate and SHALL NOT wrap.
REQ-016 On a vsync rising edge in CAPTURE:
- frame_done SHALL pulse for one cycle.
- frame_err SHALL equal (error flag OR pixel count not equal to H_ACTIVE*V_ACTIVE) during that cycle and SHALL be 0 at all other times.
- The FSM SHALL return to WAIT_FRAME, giving continuous capture.
REQ-017 A vsync rising edge and a pclk/href edge detected in the same cycle SHALL be resolved in favour of the vsync edge; that byte SHALL be ignored.
REQ-018 If cfg_done drops in any state, the FSM SHALL go to IDLE on the next cycle. No frame_done or pix_valid SHALL be produced for the aborted frame.
REQ-019 ERR_HOLD SHALL be entered from CAPTURE when synchronized vsync is still 0 after 2*H_ACTIVE*V_ACTIVE+65536 consecutive clk cycles with no pclk edge.
REQ-020 In ERR_HOLD:
- frame_done SHALL pulse once with frame_err equal to 1.
- The FSM SHALL then return to WAIT_FRAME.
REQ-021 pix_data SHALL hold its last value between pix_valid pulses.

Reset
REQ-022 While rst is 1 at a clk edge, the FSM SHALL go to IDLE. pix_valid, frame_done, frame_err, pix_data, pix_addr, all counters, byte phase, the error flag and all synchronizer/edge flops SHALL go to 0.
REQ-023 rst SHALL take priority over all other inputs. A frame in progress when rst asserts SHALL be discarded.
REQ-024 After rst deasserts, the block SHALL wait for the next vsync falling edge before capturing, even if cfg_done was already 1.

Verification
REQ-025 Nominal frame: H_ACTIVE=4, V_ACTIVE=2, pclk = clk/4, bytes 0x00..0x0F -> 8 pix_valid pulses with pix_data 0x0001, 0x0203 ... 0x0E0F and pix_addr 0..7. frame_done is 1 with frame_err=0.
REQ-026 Latency: single byte pair 0xAB, 0xCD -> pix_valid exactly 4 clk after the raw cam_pclk rise of byte 0xCD (2 sync + 1 edge + 1 output). pix_data=0xABCD.
REQ-027 Short line: one line with 3 pixels, H_ACTIVE=4 -> frame_done with frame_err=1. The next good frame reports frame_err=0.
REQ-028 Overflow: 3 lines, V_ACTIVE=2 -> pix_addr never exceeds 7, no pix_valid for the extra pixels, frame_err=1.
REQ-029 Abort: drop cfg_done mid-line -> no further pix_valid and no frame_done. Raise cfg_done -> capture resumes at pix_addr 0 on the next vsync falling edge.
REQ-030 Reset mid-frame: assert rst for 1 cycle during CAPTURE -> all outputs 0 the next cycle. The remainder of that frame produces no pix_valid.
